ex_div: RTL and testbench



---
 rtl/ex_div.sv | 152 +++++++++++++++
 tb/tb_ex_div.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// ex_div: iterative 32-bit signed/unsigned restoring divider for the EX stage.
// Holds the pipeline with stallreq_o while a DIV/DIVU runs, then writes
// quotient to LO and remainder to HI with a one-cycle whilo_o strobe.
module ex_div #(
   parameter logic [7:0] DIV_OP  = 8'b00011010,
   parameter logic [7:0] DIVU_OP = 8'b00011011,
   parameter int         WIDTH   = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [7:0]       aluop_i,
   input  logic [WIDTH-1:0] reg1_i,
   input  logic [WIDTH-1:0] reg2_i,
   input  logic             annul_i,
   output logic             stallreq_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             whilo_o
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      DONE   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] remQuo_q, remQuo_d;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic               negQuo_q, negQuo_d;
   logic               negRem_q, negRem_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d;

   logic               isDiv;
   logic               isSigned;
   logic [WIDTH-1:0]   absDividend;
   logic [WIDTH-1:0]   absDivisor;
   logic [WIDTH:0]     upper;
   logic [WIDTH:0]     diff;
   logic               geq;
   logic [WIDTH-1:0]   stepRem;
   logic [WIDTH-1:0]   stepQuo;

   assign isDiv    = (aluop_i == DIV_OP) || (aluop_i == DIVU_OP);
   assign isSigned = (aluop_i == DIV_OP);

   // Magnitudes of the operands; only meaningful while sampling in IDLE.
   assign absDividend = (isSigned && reg1_i[WIDTH-1]) ? -reg1_i : reg1_i;
   assign absDivisor  = (isSigned && reg2_i[WIDTH-1]) ? -reg2_i : reg2_i;

   // One restoring step: the upper 33 bits of the 65-bit {rem,quo,0} shift
   // are compared with the zero-extended divisor. Because the partial
   // remainder is always below the divisor, the borrow bit of the 33-bit
   // difference is exactly the "less than" result.
   assign upper   = remQuo_q[2*WIDTH-1:WIDTH-1];
   assign diff    = upper - {1'b0, divisor_q};
   assign geq     = ~diff[WIDTH];
   assign stepRem = geq ? diff[WIDTH-1:0] : upper[WIDTH-1:0];
   assign stepQuo = {remQuo_q[WIDTH-2:0], geq};

   // Stall and write strobe are combinational so annul/clear take effect in the same cycle.
   assign stallreq_o = isDiv && (state_q != DONE) && !annul_i && !clr;
   assign whilo_o    = (state_q == DONE) && !annul_i && !clr;
   assign lo_o       = lo_q;
   assign hi_o       = hi_q;

   // Next-state and datapath logic: sample operands in IDLE, iterate in ON, fix signs on the last step.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      remQuo_d  = remQuo_q;
      divisor_d = divisor_q;
      negQuo_d  = negQuo_q;
      negRem_d  = negRem_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      case (state_q)
         IDLE: begin
            if (isDiv && !annul_i) begin
               if (reg2_i == '0) begin
                  state_d = BYZERO;
               end else begin
                  state_d   = ON;
                  cnt_d     = '0;
                  remQuo_d  = {{WIDTH{1'b0}}, absDividend};
                  divisor_d = absDivisor;
                  negQuo_d  = isSigned && (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1]);
                  negRem_d  = isSigned && reg1_i[WIDTH-1];
               end
            end
         end
         BYZERO: begin
            if (annul_i) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
               lo_d    = '0;
               hi_d    = '0;
            end
         end
         ON: begin
            if (annul_i) begin
               state_d = IDLE;
            end else begin
               remQuo_d = {stepRem, stepQuo};
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = DONE;
                  lo_d    = negQuo_q ? -stepQuo : stepQuo;
                  hi_d    = negRem_q ? -stepRem : stepRem;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; clr doubles as a full pipeline flush.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         remQuo_q  <= '0;
         divisor_q <= '0;
         negQuo_q  <= 1'b0;
         negRem_q  <= 1'b0;
         lo_q      <= '0;
         hi_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         remQuo_q  <= remQuo_d;
         divisor_q <= divisor_d;
         negQuo_q  <= negQuo_d;
         negRem_q  <= negRem_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
      end
   end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for the ex_div iterative divider.
module tb_ex_div;

   localparam logic [7:0] DIV_OP  = 8'b00011010;
   localparam logic [7:0] DIVU_OP = 8'b00011011;
   localparam logic [7:0] NOP_OP  = 8'h00;

   logic        clk;
   logic        clr;
   logic [7:0]  aluop_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic        annul_i;
   logic        stallreq_o;
   logic [31:0] lo_o;
   logic [31:0] hi_o;
   logic        whilo_o;

   int assertCount = 0;
   int failCount   = 0;

   ex_div #(
      .DIV_OP  (DIV_OP),
      .DIVU_OP (DIVU_OP),
      .WIDTH   (32)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .aluop_i    (aluop_i),
      .reg1_i     (reg1_i),
      .reg2_i     (reg2_i),
      .annul_i    (annul_i),
      .stallreq_o (stallreq_o),
      .lo_o       (lo_o),
      .hi_o       (hi_o),
      .whilo_o    (whilo_o)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Runs one divide from its first EX cycle and checks stall length, strobe timing and results.
   task automatic test_divide(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] expLo, input logic [31:0] expHi,
                              input int expStall, input string name);
      int stallCnt = 0;
      int whiloAt  = 0;
      logic [31:0] gotLo = '0;
      logic [31:0] gotHi = '0;
      aluop_i = op;
      reg1_i  = a;
      reg2_i  = b;
      for (int c = 1; c <= 40 && whiloAt == 0; c++) begin
         @(negedge clk);
         if (stallreq_o) stallCnt++;
         if (whilo_o) begin
            whiloAt = c;
            gotLo   = lo_o;
            gotHi   = hi_o;
         end
         @(posedge clk); #1;
      end
      aluop_i = NOP_OP;
      assertCount++;
      if (whiloAt === 0) begin
         failCount++;
         $display("[TB] FAIL %s timeout: no whilo_o within 40 cycles", name);
      end
      assertCount++;
      if (stallCnt !== expStall) begin
         failCount++;
         $display("[TB] FAIL %s stall_cycles: got %0d expected %0d", name, stallCnt, expStall);
      end
      assertCount++;
      if (whiloAt !== expStall + 1) begin
         failCount++;
         $display("[TB] FAIL %s whilo_cycle: got %0d expected %0d", name, whiloAt, expStall + 1);
      end
      assertCount++;
      if (gotLo !== expLo) begin
         failCount++;
         $display("[TB] FAIL %s lo: got %h expected %h", name, gotLo, expLo);
      end
      assertCount++;
      if (gotHi !== expHi) begin
         failCount++;
         $display("[TB] FAIL %s hi: got %h expected %h", name, gotHi, expHi);
      end
      @(negedge clk);
      assertCount++;
      if (whilo_o !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL %s whilo_after: got %b expected 0", name, whilo_o);
      end
      assertCount++;
      if (lo_o !== expLo) begin
         failCount++;
         $display("[TB] FAIL %s lo_hold: got %h expected %h", name, lo_o, expLo);
      end
      @(posedge clk); #1;
   endtask

   // Holds clr with a divide presented, then checks the cleared outputs.
   task automatic test_reset();
      clr     = 1'b1;
      annul_i = 1'b0;
      aluop_i = DIV_OP;
      reg1_i  = 32'd10;
      reg2_i  = 32'd2;
      @(negedge clk);
      assertCount++;
      if (stallreq_o !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_stall: got %b expected 0", stallreq_o);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr     = 1'b0;
      aluop_i = NOP_OP;
      @(negedge clk);
      assertCount++;
      if (lo_o !== 32'h0 || hi_o !== 32'h0) begin
         failCount++;
         $display("[TB] FAIL reset_lohi: got lo=%h hi=%h expected 0/0", lo_o, hi_o);
      end
      assertCount++;
      if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_ctrl: got whilo=%b stall=%b expected 0/0", whilo_o, stallreq_o);
      end
      @(posedge clk); #1;
   endtask

   // Unsigned divides including all-ones dividend and large divisor.
   task automatic test_unsigned();
      test_divide(DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_100_7");
      test_divide(DIVU_OP, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h0, 33, "divu_max_1");
      test_divide(DIVU_OP, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, "divu_big");
   endtask

   // Signed divides covering each sign combination and the overflow case.
   task automatic test_signed();
      test_divide(DIV_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, "div_m7_2");
      test_divide(DIV_OP, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, "div_7_m2");
      test_divide(DIV_OP, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 33, "div_m100_m7");
      test_divide(DIV_OP, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 33, "div_overflow");
   endtask

   // Divide by zero finishes quickly with zero results.
   task automatic test_div_by_zero();
      test_divide(DIVU_OP, 32'd5, 32'd0, 32'd0, 32'd0, 2, "divu_by_zero");
   endtask

   // Annul at ON step 10 drops the divide; the next divide runs full latency.
   task automatic test_annul();
      aluop_i = DIVU_OP;
      reg1_i  = 32'd1000;
      reg2_i  = 32'd3;
      for (int c = 1; c < 12; c++) begin
         @(posedge clk); #1;
      end
      annul_i = 1'b1;
      @(negedge clk);
      assertCount++;
      if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL annul_on: got stall=%b whilo=%b expected 0/0", stallreq_o, whilo_o);
      end
      @(posedge clk); #1;
      annul_i = 1'b0;
      test_divide(DIVU_OP, 32'd9, 32'd3, 32'd3, 32'd0, 33, "annul_next");
   endtask

   // Annul during DONE suppresses the write strobe.
   task automatic test_annul_done();
      aluop_i = DIVU_OP;
      reg1_i  = 32'd20;
      reg2_i  = 32'd6;
      for (int c = 1; c < 34; c++) begin
         @(posedge clk); #1;
      end
      annul_i = 1'b1;
      @(negedge clk);
      assertCount++;
      if (whilo_o !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL annul_done_whilo: got %b expected 0", whilo_o);
      end
      assertCount++;
      if (lo_o !== 32'd3 || hi_o !== 32'd2) begin
         failCount++;
         $display("[TB] FAIL annul_done_lohi: got lo=%h hi=%h expected 3/2", lo_o, hi_o);
      end
      @(posedge clk); #1;
      annul_i = 1'b0;
      aluop_i = NOP_OP;
      @(negedge clk);
      assertCount++;
      if (whilo_o !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL annul_done_after: got %b expected 0", whilo_o);
      end
      @(posedge clk); #1;
   endtask

   // clr at ON step 20 clears results and returns to IDLE.
   task automatic test_clr_mid();
      aluop_i = DIVU_OP;
      reg1_i  = 32'd1000;
      reg2_i  = 32'd3;
      for (int c = 1; c < 22; c++) begin
         @(posedge clk); #1;
      end
      clr = 1'b1;
      @(negedge clk);
      assertCount++;
      if (stallreq_o !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL clr_stall: got %b expected 0", stallreq_o);
      end
      @(posedge clk); #1;
      clr     = 1'b0;
      aluop_i = NOP_OP;
      @(negedge clk);
      assertCount++;
      if (lo_o !== 32'h0 || hi_o !== 32'h0 || whilo_o !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL clr_outputs: got lo=%h hi=%h whilo=%b expected 0/0/0", lo_o, hi_o, whilo_o);
      end
      @(posedge clk); #1;
      test_divide(DIVU_OP, 32'd1000, 32'd3, 32'd333, 32'd1, 33, "after_clr");
   endtask

   // Two consecutive DIVU instructions produce strobes 34 cycles apart.
   task automatic test_back_to_back();
      int first  = 0;
      int second = 0;
      logic [31:0] lo1 = '0, hi1 = '0, lo2 = '0, hi2 = '0;
      aluop_i = DIVU_OP;
      reg1_i  = 32'd100;
      reg2_i  = 32'd7;
      for (int c = 1; c <= 100 && second == 0; c++) begin
         @(negedge clk);
         if (whilo_o) begin
            if (first == 0) begin
               first = c;
               lo1   = lo_o;
               hi1   = hi_o;
            end else begin
               second = c;
               lo2    = lo_o;
               hi2    = hi_o;
            end
         end
         @(posedge clk); #1;
         if (first != 0 && second == 0) begin
            reg1_i = 32'd50;
            reg2_i = 32'd6;
         end
      end
      aluop_i = NOP_OP;
      assertCount++;
      if (first !== 34) begin
         failCount++;
         $display("[TB] FAIL b2b_first_cycle: got %0d expected 34", first);
      end
      assertCount++;
      if (second - first !== 34) begin
         failCount++;
         $display("[TB] FAIL b2b_gap: got %0d expected 34", second - first);
      end
      assertCount++;
      if (lo1 !== 32'd14 || hi1 !== 32'd2) begin
         failCount++;
         $display("[TB] FAIL b2b_first_result: got lo=%h hi=%h expected e/2", lo1, hi1);
      end
      assertCount++;
      if (lo2 !== 32'd8 || hi2 !== 32'd2) begin
         failCount++;
         $display("[TB] FAIL b2b_second_result: got lo=%h hi=%h expected 8/2", lo2, hi2);
      end
      @(posedge clk); #1;
   endtask

   // Scenario sequence and summary.
   initial begin
      clr     = 1'b1;
      annul_i = 1'b0;
      aluop_i = NOP_OP;
      reg1_i  = '0;
      reg2_i  = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_by_zero();
      test_annul();
      test_annul_done();
      test_clr_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
